// File: rtl/data_bus_controller_pkg.sv
// Shared types and constants for the core data-port bus controller.
// Region decode helper lives here so the decode rule is in one place.
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    RESPOND
  } bus_state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_t;

  localparam logic [3:0]  GPIO_OFS     = 4'h0;
  localparam logic [3:0]  CYCLE_LO_OFS = 4'h4;
  localparam logic [3:0]  CYCLE_HI_OFS = 4'h8;
  localparam logic [3:0]  ID_OFS       = 4'hC;
  localparam logic [31:0] ID_VALUE     = 32'h5256_3332;

  // RAM takes priority if the MMIO window ever overlaps it.
  function automatic region_t decode_region(
    input logic [31:0] addr,
    input int unsigned aw,
    input logic [31:0] base
  );
    if ((addr >> (aw + 2)) == 32'd0)
      return REG_RAM;
    else if (addr[31:4] == base[31:4])
      return REG_MMIO;
    else
      return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/data_bus_controller_if.sv
// Core-side data port: request fields held with valid until data_ready.
// master = core, slave = bus controller.
interface data_bus_controller_if;
  logic        memory_transaction;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] data_out;
  logic [3:0]  byte_enablers;
  logic [31:0] read_data;
  logic        data_ready;

  modport master (
    output memory_transaction,
    output mem_write,
    output alu_result,
    output data_out,
    output byte_enablers,
    input  read_data,
    input  data_ready
  );

  modport slave (
    input  memory_transaction,
    input  mem_write,
    input  alu_result,
    input  data_out,
    input  byte_enablers,
    output read_data,
    output data_ready
  );
endinterface

// File: rtl/data_bus_controller_mmio_register_file.sv
// MMIO block: GPIO register, 64-bit cycle counter, high-word shadow, ID.
// Strobes come straight from the accepted request, so access is at edge T.
module mmio_register_file
  import data_bus_pkg::*;
(
  input  logic        clock,
  input  logic        sync_reset,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        write_strobe,
  input  logic        read_strobe,
  output logic [31:0] rdata,
  output logic [31:0] gpio_out
);

  logic [63:0] counter;
  logic [31:0] cycle_hi_shadow;
  logic [31:0] gpio_q;

  // Free-running cycle counter, wraps silently.
  always_ff @(posedge clock) begin
    if (!sync_reset)
      counter <= '0;
    else
      counter <= counter + 64'd1;
  end

  // GPIO register with per-lane write enables.
  always_ff @(posedge clock) begin
    if (!sync_reset) begin
      gpio_q <= '0;
    end else if (write_strobe &&
                 offset == GPIO_OFS[3:2]) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          gpio_q[8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Low-word read freezes the high word for an atomic 64-bit pair.
  always_ff @(posedge clock) begin
    if (!sync_reset)
      cycle_hi_shadow <= '0;
    else if (read_strobe &&
             offset == CYCLE_LO_OFS[3:2])
      cycle_hi_shadow <= counter[63:32];
  end

  // Read mux over the four word offsets.
  always_comb begin
    rdata = '0;
    unique case (offset)
      GPIO_OFS[3:2]:     rdata = gpio_q;
      CYCLE_LO_OFS[3:2]: rdata = counter[31:0];
      CYCLE_HI_OFS[3:2]: rdata = cycle_hi_shadow;
      ID_OFS[3:2]:       rdata = ID_VALUE;
      default:           rdata = '0;
    endcase
  end

  assign gpio_out = gpio_q;

endmodule

// File: rtl/data_bus_controller.sv
// Data-port bus controller: decodes RAM / MMIO / unmapped, sequences RAM
// wait states and returns a single-cycle data_ready to the core.
module data_bus_controller
  import data_bus_pkg::*;
#(
  parameter int          RAM_LATENCY = 1,
  parameter int          RAM_ADDR_W  = 18,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic                  clock,
  input  logic                  sync_reset,
  data_bus_controller_if.slave  bus,
  output logic [RAM_ADDR_W-1:0] ram_address,
  output logic [31:0]           ram_data_in,
  output logic [3:0]            ram_byte_enablers,
  output logic                  ram_write_enable,
  input  logic [31:0]           ram_data_out,
  output logic [31:0]           gpio_out,
  output logic                  bus_error
);

  bus_state_t state;
  bus_state_t state_n;
  region_t    region;

  logic                  accept;
  logic                  mmio_wr;
  logic                  mmio_rd;
  logic                  unmapped;
  logic                  ram_last;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic [1:0]            wait_cnt;
  logic                  first_q;
  logic [31:0]           read_data_q;
  logic [31:0]           mmio_rdata;

  assign region = decode_region(
    bus.alu_result, RAM_ADDR_W, MMIO_BASE);
  assign accept = (state == IDLE) &&
                  bus.memory_transaction;
  assign unmapped = accept &&
                    (region == REG_UNMAPPED);
  assign ram_last = (state == RAM_WAIT) &&
                    (wait_cnt == 2'd0);

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clock) begin
    if (!sync_reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state and MMIO access strobes.
  always_comb begin
    state_n = state;
    mmio_wr = 1'b0;
    mmio_rd = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (region == REG_RAM)
            state_n = RAM_WAIT;
          else
            state_n = RESPOND;
          mmio_wr = (region == REG_MMIO) &&
                    bus.mem_write;
          mmio_rd = (region == REG_MMIO) &&
                    !bus.mem_write;
        end
      end
      RAM_WAIT: begin
        if (wait_cnt == 2'd0)
          state_n = RESPOND;
      end
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Latch the request so later input changes cannot disturb it.
  always_ff @(posedge clock) begin
    if (!sync_reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.alu_result[RAM_ADDR_W+1:2];
      wdata_q <= bus.data_out;
      be_q    <= bus.byte_enablers;
      we_q    <= bus.mem_write;
    end
  end

  // Wait-state counter; first_q marks the single write-strobe cycle.
  always_ff @(posedge clock) begin
    if (!sync_reset) begin
      wait_cnt <= '0;
      first_q  <= 1'b0;
    end else if (accept) begin
      wait_cnt <= 2'(RAM_LATENCY - 1);
      first_q  <= 1'b1;
    end else if (state == RAM_WAIT) begin
      first_q <= 1'b0;
      if (wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // Read data updates only when a read completes.
  always_ff @(posedge clock) begin
    if (!sync_reset)
      read_data_q <= '0;
    else if (mmio_rd)
      read_data_q <= mmio_rdata;
    else if (unmapped && !bus.mem_write)
      read_data_q <= '0;
    else if (ram_last && !we_q)
      read_data_q <= ram_data_out;
  end

  // Sticky unmapped-access flag.
  always_ff @(posedge clock) begin
    if (!sync_reset)
      bus_error <= 1'b0;
    else if (unmapped)
      bus_error <= 1'b1;
  end

  assign ram_address       = addr_q;
  assign ram_data_in       = wdata_q;
  assign ram_byte_enablers = be_q;
  assign ram_write_enable  = (state == RAM_WAIT) &&
                             first_q && we_q;

  assign bus.read_data  = read_data_q;
  assign bus.data_ready = (state == RESPOND);

  mmio_register_file u_mmio (
    .clock        (clock),
    .sync_reset   (sync_reset),
    .offset       (bus.alu_result[3:2]),
    .wdata        (bus.data_out),
    .be           (bus.byte_enablers),
    .write_strobe (mmio_wr),
    .read_strobe  (mmio_rd),
    .rdata        (mmio_rdata),
    .gpio_out     (gpio_out)
  );

endmodule

// File: doc/data_bus_controller.md
Name: data_bus_controller

Overview:
- Sits directly downstream of the RV32I core's data port, between the core and the data RAM.
- Decodes each core data transaction to RAM, an on-chip MMIO block, or unmapped space.
- Sequences RAM wait states and returns read_data and a single-cycle data_ready handshake to the core.
- Replaces the fixed one-cycle data_ready delay register.

Parameters:
- RAM_LATENCY, 1, cycles from RAM address/enable to valid ram_data_out; legal range 1-4.
- RAM_ADDR_W, 18, RAM word-address width; RAM region = 2^(RAM_ADDR_W+2) bytes from 0x0000_0000.
- MMIO_BASE, 32'h8000_0000, base of the MMIO window (16 bytes).

Ports:
- clock  in  1  core clock
- sync_reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge)
- memory_transaction  in  1  core request valid; held with request fields until data_ready
- mem_write  in  1  1 = write, 0 = read
- alu_result  in  32  byte address
- data_out  in  32  core write data
- byte_enablers  in  4  write lane mask
- read_data  out  32  registered read data to core
- data_ready  out  1  one-cycle completion pulse
- ram_address  out  RAM_ADDR_W  word address = latched addr[RAM_ADDR_W+1:2]
- ram_data_in  out  32  RAM write data
- ram_byte_enablers  out  4  RAM lane mask
- ram_write_enable  out  1  RAM write strobe
- ram_data_out  in  32  RAM read data
- gpio_out  out  32  MMIO output register
- bus_error  out  1  sticky unmapped-access flag

Behaviour:
- Reset (sync_reset=0 at an edge):
  - FSM goes to IDLE from any state, abandoning any in-flight request.
  - read_data=0, data_ready=0, ram_write_enable=0, gpio_out=0, cycle counter=0, counter-high shadow=0, bus_error=0.
- FSM states: IDLE, RAM_WAIT, RESPOND.
- IDLE:
  - If memory_transaction=1 at edge T, latch addr, wdata, be and we, then decode:
    - RAM if addr < 2^(RAM_ADDR_W+2)
    - MMIO if addr[31:4] == MMIO_BASE[31:4]
    - otherwise unmapped.
  - RAM goes to RAM_WAIT with wait counter = RAM_LATENCY-1. MMIO and unmapped go to RESPOND.
- RAM_WAIT:
  - ram_address, ram_data_in and ram_byte_enablers are driven from the latched request.
  - ram_write_enable=1 only in the first RAM_WAIT cycle, and only for writes. No write is ever issued twice.
  - When the wait counter reaches 0: capture ram_data_out into read_data (reads only) and go to RESPOND.
  - RAM latency: data_ready is high in cycle T+RAM_LATENCY+1.
- RESPOND:
  - data_ready=1 for exactly this cycle. Next state is IDLE.
  - A memory_transaction seen in IDLE the following cycle is a new request; back-to-back requests are legal.
- MMIO map (word offsets from MMIO_BASE; read or write completes with data_ready at T+1):
  - 0x0 GPIO: read/write. A write updates only the lanes enabled in be, applied at the T→T+1 edge.
  - 0x4 CYCLE_LO: read-only. A read also copies counter[63:32] into the high shadow in the same edge.
  - 0x8 CYCLE_HI: read-only. Returns the high shadow, giving atomic 64-bit reads.
  - 0xC ID: read-only, constant 32'h5256_3332.
  - Writes to read-only offsets are ignored and do not set bus_error.
- Cycle counter:
  - 64-bit free-running, increments every non-reset cycle.
  - Wraps from all-ones to 0 without a flag.
- Unmapped access:
  - A read returns 0; a write is discarded.
  - bus_error is set and stays set until reset.
  - data_ready is still issued at T+1, so the core never stalls indefinitely.
- Other rules:
  - addr[1:0] is ignored; lane selection and sign extension belong to the core.
  - read_data holds its last value until the next read completes. Writes leave read_data unchanged.
  - Request inputs that change after acceptance have no effect. Only the latched copy is used.
  - When ram_write_enable=0, ram_* outputs may hold any value.

Decomposition:
- Package data_bus_pkg:
  - bus_state_t enum {IDLE, RAM_WAIT, RESPOND}
  - region_t enum {REG_RAM, REG_MMIO, REG_UNMAPPED}
  - MMIO offset constants GPIO_OFS, CYCLE_LO_OFS, CYCLE_HI_OFS, ID_OFS
  - ID_VALUE constant
- One sub-module, mmio_register_file. It holds the GPIO register, the cycle counter, the high shadow and the read mux.
  - Inputs: offset, wdata, be, write_strobe, read_strobe.
  - Output: rdata.

Test Plan:
- Reset, then a RAM read of 0x0000_0010 with RAM_LATENCY=1 and the RAM model returning 0xCAFE_F00D → ram_address=4; data_ready pulses exactly at T+2; read_data=0xCAFE_F00D.
- RAM write to 0x0000_0020 with be=4'b0011, data 0x1234_5678, RAM_LATENCY=3 → ram_write_enable high for exactly one cycle (T+1); ram_address=8; data_ready at T+4.
- GPIO write 0xAABB_CCDD with be=1111, then 0x0000_0011 with be=0001, then a read → gpio_out=0xAABB_CC11; read_data=0xAABB_CC11 at T+1.
- Preload counter near 0x0000_0000_FFFF_FFFF (via force); read CYCLE_LO across the wrap, then CYCLE_HI → CYCLE_HI equals the high word latched at the CYCLE_LO read, not the post-wrap value.
- Read 0x4000_0000 → data_ready at T+1; read_data=0; bus_error=1 and stays 1 through later valid accesses until sync_reset=0.
- Assert sync_reset=0 during RAM_WAIT of a RAM_LATENCY=4 read → no data_ready; all outputs 0 next cycle; a fresh request after release completes normally.
